alu_decode_stage: RTL
=====================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 Parameter CTRL_W, default 4: width of out_ctrl; SHALL be >= 4; codes zero-extended.
REQ-002 Parameter TAG_W, default 5: width of the sideband tag (destination register index).
REQ-003 Parameter ENABLE_SHIFTS, default 1: 1 = funct3 001/101 decode to shifts; 0 = those codes flag illegal.
REQ-004 Parameter CNT_W, default 8: width of the saturating illegal-op counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 flush  input  1  synchronous; discards all buffered entries.
REQ-008 in_valid  input  1  upstream presents an operation.
REQ-009 in_ready  output  1  stage can accept; equals (occupancy < 2).
REQ-010 funct7b5, opb5  input  1 each  instruction bit 30 and opcode bit 5.
REQ-011 funct3  input  3  instruction funct3.
REQ-012 alu_op  input  2  main-decoder ALU class.
REQ-013 in_tag  input  TAG_W  sideband carried unchanged with the operation.
REQ-014 out_valid  output  1  head entry valid.
REQ-015 out_ready  input  1  downstream accepts head entry.
REQ-016 out_ctrl  output  CTRL_W  registered ALU control code of head entry.
REQ-017 out_illegal  output  1  head entry decoded as illegal.
REQ-018 out_tag  output  TAG_W  tag of head entry.
REQ-019 illegal_count  output  CNT_W  saturating count of accepted illegal operations.

Function
REQ-020 Codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
REQ-021 alu_op 00 -> ADD; 01 -> SUB; 11 -> ADD with illegal=1.
REQ-022 alu_op 10, funct3: 000 -> SUB if funct7b5&opb5 else ADD; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND.
REQ-023 alu_op 10, funct3 001 -> SLL; 101 -> SRA if funct7b5 else SRL (opb5 ignored); with ENABLE_SHIFTS=0 both -> ADD, illegal=1.
REQ-024 Decode is combinational on input; code, illegal bit and tag are written into a 2-entry FIFO (skid buffer) on in_valid & in_ready.
REQ-025 Latency: an entry accepted into an empty stage appears on out_valid/out_ctrl the next cycle.
REQ-026 Pop on out_valid & out_ready; outputs reflect head entry; ordering strictly FIFO.
REQ-027 Occupancy 0/1/2; push-only +1, pop-only -1, push and pop same cycle unchanged.
REQ-028 At occupancy 2 in_ready=0; a same-cycle pop does not re-enable in_ready in that cycle (no combinational ready path from out_ready).
REQ-029 Outputs stable while out_valid=1 and out_ready=0.
REQ-030 When out_valid=0, out_ctrl, out_illegal, out_tag hold their last values; no bench checks them.
REQ-031 illegal_count increments by 1 on each accepted (pushed) illegal entry; holds at 2^CNT_W-1.
REQ-032 flush=1: next edge occupancy=0, out_valid=0; push in the flush cycle is dropped and not counted; illegal_count unchanged.
REQ-033 out_valid and in_ready are glitch-free registered/count-derived signals only.

Reset
REQ-034 reset=1 immediately forces occupancy 0, out_valid 0, out_ctrl 0, out_illegal 0, out_tag 0, illegal_count 0; in_ready 1.
REQ-035 Reset asserted mid-transfer discards all entries; first post-reset acceptance behaves as from empty.

Verification
REQ-036 alu_op=10, funct3=000, funct7b5=1, opb5=1, out_ready=1 -> next cycle out_valid=1, out_ctrl=0001, out_illegal=0.
REQ-037 Sweep funct3 with alu_op=10, funct7b5=1, opb5=0 -> 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRA, 110 OR, 111 AND.
REQ-038 out_ready=0, push 3 ops with tags 1,2,3 -> in_ready=0 after second; tags 1,2 emerge in order once out_ready=1, tag 3 only if re-presented.
REQ-039 CNT_W=2, push 5 alu_op=11 ops -> illegal_count 1,2,3,3,3; each out_illegal=1, out_ctrl=0000.
REQ-040 Occupancy 2, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, illegal_count unchanged.
REQ-041 Occupancy 1, assert reset asynchronously between edges -> out_valid=0 and illegal_count=0 before next edge.

Source files
------------

// File: rtl/alu_decode_stage.sv
// ALU control decoder feeding a 2-entry skid FIFO; each entry carries the
// decoded control code, an illegal flag and a sideband tag.
module alu_decode_stage #(
    parameter int CTRL_W        = 4,
    parameter int TAG_W         = 5,
    parameter int ENABLE_SHIFTS = 1,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              funct7b5,
    input  logic              opb5,
    input  logic [2:0]        funct3,
    input  logic [1:0]        alu_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_illegal,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  illegal_count
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_code_t;

    alu_code_t         dec_code;
    logic              dec_illegal;
    logic [CTRL_W-1:0] dec_ctrl;

    always_comb begin
        dec_code    = ALU_ADD;
        dec_illegal = 1'b0;
        case (alu_op)
            2'b00: dec_code = ALU_ADD;
            2'b01: dec_code = ALU_SUB;
            2'b11: dec_illegal = 1'b1;
            default: begin
                case (funct3)
                    3'b000: dec_code = (funct7b5 & opb5) ? ALU_SUB : ALU_ADD;
                    3'b010: dec_code = ALU_SLT;
                    3'b011: dec_code = ALU_SLTU;
                    3'b100: dec_code = ALU_XOR;
                    3'b110: dec_code = ALU_OR;
                    3'b111: dec_code = ALU_AND;
                    3'b001: begin
                        if (ENABLE_SHIFTS != 0) dec_code = ALU_SLL;
                        else                    dec_illegal = 1'b1;
                    end
                    default: begin
                        if (ENABLE_SHIFTS != 0) dec_code = funct7b5 ? ALU_SRA : ALU_SRL;
                        else                    dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign dec_ctrl = CTRL_W'(dec_code);

    // Head entry lives directly in the output registers; slot holds the second entry.
    logic [1:0]        count;
    logic [CTRL_W-1:0] slot_ctrl;
    logic              slot_illegal;
    logic [TAG_W-1:0]  slot_tag;
    logic              push;
    logic              pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count         <= '0;
            out_ctrl      <= '0;
            out_illegal   <= 1'b0;
            out_tag       <= '0;
            slot_ctrl     <= '0;
            slot_illegal  <= 1'b0;
            slot_tag      <= '0;
            illegal_count <= '0;
        end else begin
            if (flush) begin
                count <= '0;
            end else begin
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
                if (push && ((count == 2'd0) || (count == 2'd1 && pop))) begin
                    out_ctrl    <= dec_ctrl;
                    out_illegal <= dec_illegal;
                    out_tag     <= in_tag;
                end else if (pop && count == 2'd2) begin
                    out_ctrl    <= slot_ctrl;
                    out_illegal <= slot_illegal;
                    out_tag     <= slot_tag;
                end
                if (push && count == 2'd1 && !pop) begin
                    slot_ctrl    <= dec_ctrl;
                    slot_illegal <= dec_illegal;
                    slot_tag     <= in_tag;
                end
            end
            if (push && dec_illegal && (illegal_count != '1))
                illegal_count <= illegal_count + 1'b1;
        end
    end

endmodule
